// File: rtl/mcp41010_pkg.sv
// mcp41010_pkg
// Shared constants and types for the MCP41010 SPI receive model:
// command-field codes, frame length and the frame FSM state encoding.
package mcp41010_pkg;

  localparam logic [1:0] C_NOP   = 2'b00;
  localparam logic [1:0] C_WRITE = 2'b01;
  localparam logic [1:0] C_SHDN  = 2'b10;

  localparam int FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } frame_state_t;

endpackage

// File: rtl/mcp41010_slave_if.sv
// mcp41010_slave_if
// Bundles the SPI pins and the decoded-state outputs of the MCP41010 model.
//   cs, sclk, mosi   : SPI pins (driven by the master side)
//   rx_word          : last complete 16-bit frame
//   frame_valid      : 1-cycle pulse, rx_word updated
//   frame_err        : 1-cycle pulse, frame discarded
//   wiper, wiper_upd : wiper code and its write pulse
//   shdn             : shutdown state
interface mcp41010_slave_if;
  logic        cs;
  logic        sclk;
  logic        mosi;
  logic [15:0] rx_word;
  logic        frame_valid;
  logic        frame_err;
  logic [7:0]  wiper;
  logic        wiper_upd;
  logic        shdn;

  modport master (
    output cs, sclk, mosi,
    input  rx_word, frame_valid, frame_err, wiper, wiper_upd, shdn
  );

  modport slave (
    input  cs, sclk, mosi,
    output rx_word, frame_valid, frame_err, wiper, wiper_upd, shdn
  );
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
// STAGES-deep synchronizer followed by one delay flop for edge detection.
//   clk, rst : clock, synchronous active-low reset
//   d        : asynchronous input pin
//   level    : synchronized level
//   rise     : level went 0 -> 1 this cycle
//   fall     : level went 1 -> 0 this cycle
// RST_VAL sets the idle level the chain resets to (1 for chip select) so
// that leaving reset never fabricates an edge.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic prev;

  generate
    if (STAGES == 0) begin : g_bypass
      assign level = d;
    end else begin : g_sync
      logic [STAGES-1:0] chain;
      always_ff @(posedge clk) begin
        if (!rst) begin
          chain <= {STAGES{RST_VAL}};
        end else begin
          chain[0] <= d;
          for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
      end
      assign level = chain[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) prev <= RST_VAL;
    else      prev <= level;
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/mcp41010_slave.sv
// mcp41010_slave
// Receive-side model of the MCP41010 SPI port. Assembles 16-bit frames
// (mode 0,0, MSB first) and keeps wiper/shutdown state like the chip.
//   clk, rst : clock, synchronous active-low reset
//   bus      : slave modport (cs/sclk/mosi in; rx_word, frame_valid,
//              frame_err, wiper, wiper_upd, shdn out)
//
// state | meaning
// IDLE  | waiting for synchronized cs low
// SHIFT | shifting mosi on sclk rises until cs goes high
// DONE  | one cycle: accept (16 bits) or reject the frame, decode command
module mcp41010_slave
  import mcp41010_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] WIPER_RST   = 8'h80
) (
  input  logic              clk,
  input  logic              rst,
  mcp41010_slave_if.slave   bus
);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(bus.cs),
    .level(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(bus.sclk),
    .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  // mosi goes through the same depth so it stays aligned with sclk; only
  // its level is used.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d(bus.mosi),
    .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  frame_state_t state, state_nxt;
  logic [4:0]   cnt, cnt_nxt;
  logic [15:0]  sr, sr_nxt;
  logic [15:0]  rx_word, rx_word_nxt;
  logic [7:0]   wiper, wiper_nxt;
  logic         shdn, shdn_nxt;
  logic         frame_valid, frame_valid_nxt;
  logic         frame_err, frame_err_nxt;
  logic         wiper_upd, wiper_upd_nxt;
  logic [7:0]   cmd;

  assign cmd = sr[15:8];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sr          <= '0;
      rx_word     <= '0;
      wiper       <= WIPER_RST;
      shdn        <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      wiper_upd   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sr          <= sr_nxt;
      rx_word     <= rx_word_nxt;
      wiper       <= wiper_nxt;
      shdn        <= shdn_nxt;
      frame_valid <= frame_valid_nxt;
      frame_err   <= frame_err_nxt;
      wiper_upd   <= wiper_upd_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    sr_nxt          = sr;
    rx_word_nxt     = rx_word;
    wiper_nxt       = wiper;
    shdn_nxt        = shdn;
    frame_valid_nxt = 1'b0;
    frame_err_nxt   = 1'b0;
    wiper_upd_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (!cs_s) begin
          cnt_nxt   = '0;
          sr_nxt    = '0;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        // cs release wins over a coincident sclk rise.
        if (cs_s) begin
          state_nxt = DONE;
        end else if (sclk_rise) begin
          sr_nxt = {sr[14:0], mosi_s};
          // Saturate at FRAME_BITS+1 so any overlong frame stays invalid.
          if (cnt != 5'(FRAME_BITS + 1)) cnt_nxt = cnt + 5'd1;
        end
      end

      DONE: begin
        state_nxt = IDLE;
        if (cnt == 5'(FRAME_BITS)) begin
          rx_word_nxt     = sr;
          frame_valid_nxt = 1'b1;
          if (cmd[0]) begin
            if (cmd[5:4] == C_WRITE) begin
              wiper_nxt     = sr[7:0];
              shdn_nxt      = 1'b0;
              wiper_upd_nxt = 1'b1;
            end else if (cmd[5:4] == C_SHDN) begin
              shdn_nxt = 1'b1;
            end
          end
        end else begin
          frame_err_nxt = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rx_word     = rx_word;
  assign bus.frame_valid = frame_valid;
  assign bus.frame_err   = frame_err;
  assign bus.wiper       = wiper;
  assign bus.wiper_upd   = wiper_upd;
  assign bus.shdn        = shdn;

endmodule

// File: tb/tb_mcp41010_slave.sv
// tb_mcp41010_slave
// Directed frames with hand-computed expectations pushed to a scoreboard;
// a monitor pops an entry on every frame_valid/frame_err pulse.
module tb_mcp41010_slave;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mcp41010_slave_if bus ();

  mcp41010_slave #(.SYNC_STAGES(2), .WIPER_RST(8'h80)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        err;
    logic [15:0] rx;
    logic        upd;
    logic [7:0]  wiper;
    logic        shdn;
    int          due;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SYNC_STAGES(2) + 2 cycles from cs rise at the pin to the pulses.
  task automatic send(input logic [31:0] data, input int nbits, input bit hold_high,
                      input logic err, input logic [15:0] rx, input logic upd,
                      input logic [7:0] wiper, input logic shdn);
    exp_t e;
    bus.cs   = 1'b0;
    bus.sclk = 1'b0;
    repeat (2) tick();
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.mosi = data[i];
      bus.sclk = 1'b0;
      tick();
      bus.sclk = 1'b1;
      tick();
    end
    if (!hold_high) begin
      bus.sclk = 1'b0;
      tick();
    end
    bus.cs  = 1'b1;
    e.err   = err;
    e.rx    = rx;
    e.upd   = upd;
    e.wiper = wiper;
    e.shdn  = shdn;
    e.due   = cyc + 4;
    sb.push_back(e);
    repeat (2) tick();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_wiper"}, {24'd0, bus.wiper}, 32'h80);
    chk({tag, "_shdn"},  {31'd0, bus.shdn}, 32'h0);
    chk({tag, "_rx"},    {16'd0, bus.rx_word}, 32'h0);
    chk({tag, "_pulses"}, {29'd0, bus.frame_valid, bus.frame_err, bus.wiper_upd}, 32'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.frame_valid === 1'b1 || bus.frame_err === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b with empty scoreboard (cycle %0d)",
                 bus.frame_valid, bus.frame_err, cyc);
      end else begin
        e = sb.pop_front();
        chk("frame_err",   {31'd0, bus.frame_err}, {31'd0, e.err});
        chk("frame_valid", {31'd0, bus.frame_valid}, {31'd0, ~e.err});
        chk("rx_word",     {16'd0, bus.rx_word}, {16'd0, e.rx});
        chk("wiper_upd",   {31'd0, bus.wiper_upd}, {31'd0, e.upd});
        chk("wiper",       {24'd0, bus.wiper}, {24'd0, e.wiper});
        chk("shdn",        {31'd0, bus.shdn}, {31'd0, e.shdn});
        chk("latency",     cyc, e.due);
      end
    end else if (bus.wiper_upd === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL stray_wiper_upd: got 1 expected 0 (cycle %0d)", cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cs   = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    rst      = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_reset_values("reset");

    //        data         bits hold err  rx        upd  wiper  shdn
    send(32'h11A5,   16, 0, 1'b0, 16'h11A5, 1'b1, 8'hA5, 1'b0);
    send(32'h2100,   16, 0, 1'b0, 16'h2100, 1'b0, 8'hA5, 1'b1);
    send(32'h1133,   16, 1, 1'b0, 16'h1133, 1'b1, 8'h33, 1'b0);
    send(32'h1144,   15, 0, 1'b1, 16'h1133, 1'b0, 8'h33, 1'b0);
    send(32'h2100,   16, 0, 1'b0, 16'h2100, 1'b0, 8'h33, 1'b1);
    send(32'h11234,  17, 0, 1'b1, 16'h2100, 1'b0, 8'h33, 1'b1);
    send(32'h1077,   16, 0, 1'b0, 16'h1077, 1'b0, 8'h33, 1'b1);
    send(32'h3077,   16, 0, 1'b0, 16'h3077, 1'b0, 8'h33, 1'b1);
    send(32'hD366,   16, 0, 1'b0, 16'hD366, 1'b1, 8'h66, 1'b0);

    // Abort 16'h11FF after 8 bits with reset.
    bus.cs   = 1'b0;
    bus.sclk = 1'b0;
    repeat (2) tick();
    for (int i = 15; i >= 8; i--) begin
      bus.mosi = (i == 12 || i == 8) ? 1'b1 : 1'b0;
      bus.sclk = 1'b0;
      tick();
      bus.sclk = 1'b1;
      tick();
    end
    rst      = 1'b0;
    bus.cs   = 1'b1;
    bus.sclk = 1'b0;
    repeat (2) tick();
    check_reset_values("in_reset");
    rst = 1'b1;
    repeat (4) tick();
    check_reset_values("after_reset");

    send(32'h1122,   16, 0, 1'b0, 16'h1122, 1'b1, 8'h22, 1'b0);

    repeat (10) tick();
    chk("scoreboard_drained", sb.size(), 32'd0);
    chk("final_wiper", {24'd0, bus.wiper}, 32'h22);
    chk("final_shdn",  {31'd0, bus.shdn}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
